debouncer_multi: RTL and testbench
==================================

Name: debouncer_multi

Overview:
- Parametrised N-channel debouncer for push-buttons and switches on the lab board; the successor to the single-channel debouncer.
- Each channel has its own input synchroniser and its own stability counter.
- Per channel it produces a clean level, a one-cycle rising-edge pulse and a one-cycle falling-edge pulse.
- Sits between raw board pins and the CPU/control logic. The pulse outputs replace ad hoc edge detection downstream.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- STABLE_CYCLES, 1000: consecutive synchronised cycles a new value must hold before it is accepted (>=2).
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (>=2).
- INIT_LEVEL, 0: reset value of the synchroniser flops and of the debounced level, applied to all channels.
- PULSE_MASK, all ones (CHANNELS bits): bit i=0 forces rise_o[i] and fall_o[i] to 0; level_o[i] is unaffected.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- entrada  input  CHANNELS  raw asynchronous inputs, one bit per channel
- level_o  output  CHANNELS  debounced level
- rise_o  output  CHANNELS  one-cycle pulse when level_o goes 0->1
- fall_o  output  CHANNELS  one-cycle pulse when level_o goes 1->0
- any_rise_o  output  1  registered OR of rise_o; asserted the cycle after any rise_o bit
- stable_cnt_max_o  output  1  high while every channel's counter is 0 (all inputs settled); status only

Behaviour:
- Reset (rst=1 at posedge clk), all synchronous:
  - synchroniser flops and level_o <= INIT_LEVEL;
  - counters <= 0;
  - rise_o, fall_o, any_rise_o <= 0;
  - stable_cnt_max_o <= 1.
- Reset mid-count discards the partial count; no pulse is generated by reset or by its release.
- Synchroniser: entrada[i] passes through SYNC_STAGES flops to give s[i]. The counter logic uses only s[i].
- Counter width: $clog2(STABLE_CYCLES). It saturates by construction and never wraps.
- Per channel, each cycle:
  - if s[i]==level_o[i]: cnt <= 0.
  - else if cnt==STABLE_CYCLES-1: level_o[i] <= s[i]; cnt <= 0; set rise_o[i] or fall_o[i] per direction (AND PULSE_MASK[i]) for exactly that cycle.
  - else: cnt <= cnt+1.
- Any cycle where s[i] equals the current level aborts the pending change (glitch rejection). A glitch shorter than STABLE_CYCLES synchronised cycles never reaches level_o.
- Latency: a clean step on entrada[i] captured at edge E changes level_o[i] at edge E+SYNC_STAGES+STABLE_CYCLES-1.
  - rise_o/fall_o are asserted in the same cycle level_o changes.
  - any_rise_o follows one cycle later.
- Pulses are never asserted for two consecutive cycles on the same channel. The minimum spacing between pulses on one channel is STABLE_CYCLES cycles.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- stable_cnt_max_o is registered: 1 when all counters are 0 on the previous cycle.
- Input held constant forever: no pulses; level_o stays constant.

Decomposition:
- Package debounce_pkg:
  - localparam function cnt_width(stable) returning $clog2(stable);
  - default parameter constants DEF_STABLE_CYCLES=1000, DEF_SYNC_STAGES=2.
- Sub-module debounce_channel: one synchroniser, counter, level and rise/fall register, with parameters STABLE_CYCLES, SYNC_STAGES, INIT_LEVEL.
- Top level: generate loop over CHANNELS instantiating debounce_channel, plus PULSE_MASK gating, the any_rise_o OR-reduce register and the stable_cnt_max_o logic.

Test Plan (CHANNELS=4, STABLE_CYCLES=8, SYNC_STAGES=2, INIT_LEVEL=0 unless stated):
- Reset, then entrada=4'b0001 held from edge 0 -> level_o[0]=1 and rise_o=4'b0001 for one cycle at edge 9; any_rise_o=1 at edge 10; other channels stay 0.
- entrada[1] pulses high for 5 cycles, then low -> level_o, rise_o and fall_o all remain 0; stable_cnt_max_o returns to 1 once the input settles.
- entrada[2] high for 20 cycles, then low -> rise_o[2] once; fall_o[2] once, 9 cycles after the falling edge; level_o[2] tracks accordingly.
- rst asserted for 1 cycle after 5 stable-high cycles on channel 3 -> no pulse; the count restarts, and rise_o[3] occurs 9 cycles after rst deasserts.
- entrada=4'b1111 at once -> rise_o=4'b1111 in the same cycle, one pulse each; with PULSE_MASK=4'b0101, rise_o=4'b0101 while level_o=4'b1111.
- INIT_LEVEL=1 with entrada held at 1 through reset -> no fall_o or rise_o after reset; level_o=4'b1111 throughout.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debouncer family.
package debounce_pkg;

  localparam int unsigned DEF_STABLE_CYCLES = 1000;
  localparam int unsigned DEF_SYNC_STAGES   = 2;

  // Width of a stability counter that only ever needs to reach stable-1.
  function automatic int unsigned cnt_width(input int unsigned stable);
    return $clog2(stable);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: input synchroniser, stability counter, level and edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic cnt_zero_o
);

  localparam int unsigned      CntW    = cnt_width(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Shift the raw pin into the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din_i};
  end

  // Count consecutive cycles the synchronised input differs from the level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_s == level_q) begin
      // Any agreeing sample throws away a pending change.
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      level_d = sync_s;
      cnt_d   = '0;
      rise_d  = sync_s;
      fall_d  = ~sync_s;
    end else begin
      cnt_d = cnt_q + CntOne;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign cnt_zero_o = (cnt_q == '0);

endmodule

// File: rtl/debouncer_multi.sv
// N independent debounce lanes plus pulse masking and aggregate status flags.
module debouncer_multi
  import debounce_pkg::*;
#(
  parameter int unsigned          CHANNELS      = 4,
  parameter int unsigned          STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned          SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter logic                 INIT_LEVEL    = 1'b0,
  parameter logic [CHANNELS-1:0]  PULSE_MASK    = {CHANNELS{1'b1}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] entrada,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic                any_rise_o,
  output logic                stable_cnt_max_o
);

  logic [CHANNELS-1:0] rise_raw, fall_raw, cnt_zero;
  logic                any_rise_q, any_rise_d;
  logic                stable_q, stable_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES),
      .INIT_LEVEL    (INIT_LEVEL)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .din_i      (entrada[i]),
      .level_o    (level_o[i]),
      .rise_o     (rise_raw[i]),
      .fall_o     (fall_raw[i]),
      .cnt_zero_o (cnt_zero[i])
    );
  end

  // Masked lanes keep their level but never pulse.
  assign rise_o = rise_raw & PULSE_MASK;
  assign fall_o = fall_raw & PULSE_MASK;

  // Next-state for the aggregate flags.
  always_comb begin
    any_rise_d = |rise_o;
    stable_d   = &cnt_zero;
  end

  // Aggregate flag registers; all lanes counting zero right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_rise_q <= 1'b0;
      stable_q   <= 1'b1;
    end else begin
      any_rise_q <= any_rise_d;
      stable_q   <= stable_d;
    end
  end

  assign any_rise_o       = any_rise_q;
  assign stable_cnt_max_o = stable_q;

endmodule

// File: tb/tb_debouncer_multi.sv
// Scoreboard bench: three DUT variants driven in lockstep against a windowed reference model.
module tb_debouncer_multi;

  localparam int CH   = 4;
  localparam int ST   = 8;
  localparam int SS   = 2;
  localparam int NDUT = 3;

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       anyr;
    logic       stab;
  } exp_t;
  typedef exp_t [NDUT-1:0] frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] entrada = '0;

  logic [3:0] lvl_w  [NDUT];
  logic [3:0] rise_w [NDUT];
  logic [3:0] fall_w [NDUT];
  logic       anyr_w [NDUT];
  logic       stab_w [NDUT];

  int total = 0;
  int bad   = 0;

  frame_t exp_q[$];

  always #5 clk = ~clk;

  debouncer_multi #(.CHANNELS(CH), .STABLE_CYCLES(ST), .SYNC_STAGES(SS),
                    .INIT_LEVEL(1'b0), .PULSE_MASK(4'b1111)) u_dut0 (
    .clk(clk), .rst(rst), .entrada(entrada), .level_o(lvl_w[0]), .rise_o(rise_w[0]),
    .fall_o(fall_w[0]), .any_rise_o(anyr_w[0]), .stable_cnt_max_o(stab_w[0]));

  debouncer_multi #(.CHANNELS(CH), .STABLE_CYCLES(ST), .SYNC_STAGES(SS),
                    .INIT_LEVEL(1'b0), .PULSE_MASK(4'b0101)) u_dut1 (
    .clk(clk), .rst(rst), .entrada(entrada), .level_o(lvl_w[1]), .rise_o(rise_w[1]),
    .fall_o(fall_w[1]), .any_rise_o(anyr_w[1]), .stable_cnt_max_o(stab_w[1]));

  debouncer_multi #(.CHANNELS(CH), .STABLE_CYCLES(ST), .SYNC_STAGES(SS),
                    .INIT_LEVEL(1'b1), .PULSE_MASK(4'b1111)) u_dut2 (
    .clk(clk), .rst(rst), .entrada(entrada), .level_o(lvl_w[2]), .rise_o(rise_w[2]),
    .fall_o(fall_w[2]), .any_rise_o(anyr_w[2]), .stable_cnt_max_o(stab_w[2]));

  function automatic logic [3:0] mask_of(input int d);
    return (d == 1) ? 4'b0101 : 4'b1111;
  endfunction

  function automatic bit init_of(input int d);
    return (d == 2);
  endfunction

  // Reference model: pin delayed SS samples, level flips once the last ST samples all disagree.
  bit         m_pipe [NDUT][CH][SS];
  bit         m_hist [NDUT][CH][ST];
  bit   [3:0] m_lvl  [NDUT];
  bit   [3:0] m_rise [NDUT];
  bit   [3:0] m_fall [NDUT];
  bit         m_anyr [NDUT];
  bit         m_stab [NDUT];
  bit         m_allz [NDUT];

  task automatic model_step(input bit r, input logic [3:0] e, output frame_t f);
    bit       ini, s, acc, anyr_n, stab_n;
    bit [3:0] mk, zero;
    for (int d = 0; d < NDUT; d++) begin
      ini = init_of(d);
      mk  = mask_of(d);
      if (r) begin
        for (int c = 0; c < CH; c++) begin
          for (int k = 0; k < SS; k++) m_pipe[d][c][k] = ini;
          for (int k = 0; k < ST; k++) m_hist[d][c][k] = ini;
        end
        m_lvl[d]  = {4{ini}};
        m_rise[d] = '0;
        m_fall[d] = '0;
        m_anyr[d] = 1'b0;
        m_stab[d] = 1'b1;
        m_allz[d] = 1'b1;
      end else begin
        anyr_n = |m_rise[d];
        stab_n = m_allz[d];
        for (int c = 0; c < CH; c++) begin
          s = m_pipe[d][c][SS-1];
          for (int k = ST - 1; k > 0; k--) m_hist[d][c][k] = m_hist[d][c][k-1];
          m_hist[d][c][0] = s;
          acc = 1'b1;
          for (int k = 0; k < ST; k++) if (m_hist[d][c][k] == m_lvl[d][c]) acc = 1'b0;
          zero[c] = (s == m_lvl[d][c]) || acc;
          m_rise[d][c] = 1'b0;
          m_fall[d][c] = 1'b0;
          if (acc) begin
            m_lvl[d][c]  = ~m_lvl[d][c];
            m_rise[d][c] = m_lvl[d][c] & mk[c];
            m_fall[d][c] = ~m_lvl[d][c] & mk[c];
          end
          for (int k = SS - 1; k > 0; k--) m_pipe[d][c][k] = m_pipe[d][c][k-1];
          m_pipe[d][c][0] = e[c];
        end
        m_anyr[d] = anyr_n;
        m_stab[d] = stab_n;
        m_allz[d] = &zero;
      end
      f[d].lvl  = m_lvl[d];
      f[d].rise = m_rise[d];
      f[d].fall = m_fall[d];
      f[d].anyr = m_anyr[d];
      f[d].stab = m_stab[d];
    end
  endtask

  task automatic check(input string name, input int d, input logic [3:0] act,
                       input logic [3:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut%0d at %0t: got %b expected %b", name, d, $time, act, want);
    end
  endtask

  // Drive one cycle, then record what the model says the DUTs must show after that edge.
  task automatic tick(input bit r, input logic [3:0] e);
    frame_t f;
    rst     = r;
    entrada = e;
    @(posedge clk);
    model_step(r, e, f);
    exp_q.push_back(f);
    #1;
  endtask

  // Monitor: every cycle the DUTs present a fresh output set; compare against the oldest entry.
  always @(negedge clk) begin
    frame_t f;
    if (exp_q.size() > 0) begin
      f = exp_q.pop_front();
      for (int d = 0; d < NDUT; d++) begin
        check("level", d, lvl_w[d], f[d].lvl);
        check("rise", d, rise_w[d], f[d].rise);
        check("fall", d, fall_w[d], f[d].fall);
        check("any_rise", d, {3'b0, anyr_w[d]}, {3'b0, f[d].anyr});
        check("stable", d, {3'b0, stab_w[d]}, {3'b0, f[d].stab});
      end
    end
  end

  int         lat;
  logic [3:0] cur;
  int         hold [CH];

  initial begin
    // Reset, then a clean step on channel 0; rise must land on the tenth sampling edge (edge 9).
    repeat (3) tick(1'b1, 4'b0000);
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      tick(1'b0, 4'b0001);
      if (rise_w[0][0] === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("rise_latency", 0, 4'(lat), 4'(9));
    tick(1'b0, 4'b0001);
    check("any_rise_follows", 0, {3'b0, anyr_w[0]}, 4'b0001);

    // Short glitch on channel 1 must be rejected.
    repeat (5) tick(1'b0, 4'b0011);
    repeat (15) tick(1'b0, 4'b0001);

    // Long pulse on channel 2: one rise and one fall.
    repeat (20) tick(1'b0, 4'b0101);
    repeat (15) tick(1'b0, 4'b0001);

    // Reset mid-count on channel 3 discards the partial count.
    repeat (5) tick(1'b0, 4'b1001);
    tick(1'b1, 4'b1001);
    repeat (14) tick(1'b0, 4'b1001);

    // All channels rise together after settling low.
    repeat (12) tick(1'b0, 4'b0000);
    repeat (14) tick(1'b0, 4'b1111);

    // Inputs held high through reset: the INIT_LEVEL=1 variant must stay quiet.
    repeat (3) tick(1'b1, 4'b1111);
    repeat (20) tick(1'b0, 4'b1111);

    // Randomised per-channel hold times around the stability threshold.
    cur = 4'b1111;
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          cur[c]  = 1'($urandom_range(0, 1));
          hold[c] = int'($urandom_range(1, 14));
        end else begin
          hold[c]--;
        end
      end
      tick(($urandom_range(0, 299) == 0), cur);
    end

    @(negedge clk);
    #1;
    check("queue_drained", 0, 4'(exp_q.size()), 4'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
